reg_lock_arb: RTL and testbench
===============================

REG_LOCK_ARB -- requirements
Module: reg_lock_arb

Interface
- REQ-001: Parameter NP, default 4: number of requesting grant-checker ports; legal range 1..8.
- REQ-002: Parameter NU, default 2: number of writeback unlock ports; legal range 1..4.
- REQ-003: Localparam NR = rv64g_pkg::NUM_REGS: register count and lock-vector width.
- REQ-004: Localparam IW = $clog2(NR): unlock index width.
- REQ-005: clk_i input 1: the single clock; all state updates on the rising edge.
- REQ-006: arst_ni input 1: asynchronous, active-low reset.
- REQ-007: arb_req_i input NP: per-port request for a lock grant.
- REQ-008: arb_gnt_o output NP: per-port grant, at most one bit set.
- REQ-009: lock_req_i input NP x NR: per-port set of registers to lock on grant.
- REQ-010: locks_o output NR: current registered lock vector, broadcast to all checkers.
- REQ-011: unlock_valid_i input NU: per-port writeback-complete strobe.
- REQ-012: unlock_idx_i input NU x IW: per-port index of the register to unlock.
- REQ-013: flush_i input 1: pipeline flush (jump/redirect); suppresses grants this cycle.
- REQ-014: busy_o output 1: high when any bit of locks_o is set.

Function
- REQ-015: The block shall hold the lock vector in an NR-bit register locks_q; locks_o = locks_q, and busy_o = |locks_q.
- REQ-016: Grant shall be combinational in the same cycle as the request, round-robin over arb_req_i, starting search at pointer rr_q (IW_P = $clog2(NP) bits, wrap NP-1 -> 0).
- REQ-017: arb_gnt_o shall be all zero when flush_i = 1 or arb_req_i = 0.
- REQ-018: A port shall not be granted when (lock_req_i[p] & locks_q) != 0; that port is skipped, and the search continues to the next requester.
- REQ-019: On a cycle with grant to port g, rr_q shall update to (g+1) mod NP at the next edge; with no grant, rr_q shall hold.
- REQ-020: The next-state update shall be locks_q <= (locks_q & ~unlock_mask) | (granted ? lock_req_i[g] : 0), where unlock_mask is the OR over valid unlock ports of a one-hot decode of unlock_idx_i.
- REQ-021: When the same register is unlocked and newly locked in the same cycle, the lock shall win.
- REQ-022: Bit 0 (x0) shall never be set; lock_req_i bit 0 shall be ignored.
- REQ-023: unlock_idx_i >= NR shall be ignored, and unlocking an already-clear bit shall be a no-op.
- REQ-024: Duplicate indices across unlock ports in one cycle shall be equivalent to a single unlock.
- REQ-025: flush_i shall not clear locks_q, because in-flight writebacks still unlock.
- REQ-026: Unlocks shall proceed normally during flush.
- REQ-027: A grant shall be visible to the checker in the same cycle it is asserted.
- REQ-028: The locked bits shall appear on locks_o in the following cycle.

Reset
- REQ-029: While arst_ni = 0: locks_q = 0, rr_q = 0, locks_o = 0, busy_o = 0.
- REQ-030: While arst_ni = 0, arb_gnt_o shall be forced to 0 regardless of inputs.
- REQ-031: Reset assertion mid-operation shall discard all locks immediately, without waiting for a clock edge.
- REQ-032: The first grant after reset deassertion shall search from port 0.

Verification
- REQ-033: Reset, then arb_req_i = 4'b0101 with disjoint lock_req_i -> gnt = 0001, next cycle gnt = 0100, next cycle gnt = 0001.
- REQ-034: Port 1 requests lock of reg 5 while locks_q[5] = 1 -> port 1 is not granted; port 2 requesting reg 7 is granted and locks_q[7] = 1 next cycle.
- REQ-035: locks_q[9] = 1; unlock_valid_i = 01 with idx 9, and port 0 locks reg 9 in the same cycle -> locks_q[9] = 1 next cycle, no other bits changed.
- REQ-036: Both unlock ports at idx 3 and idx 12 with locks_q = {3,12} -> locks_q = 0 and busy_o = 0 next cycle.
- REQ-037: flush_i = 1 with arb_req_i = 1111 -> gnt = 0, rr_q unchanged, and pending unlock of reg 4 still clears bit 4.
- REQ-038: arst_ni pulsed low between edges with locks_q = 0xF0 -> locks_o = 0 immediately, and lock_req_i bit 0 set afterwards never sets locks_q[0].

Source files
------------

// File: rtl/reg_lock_arb.sv
// Register lock arbiter.
//
// Tracks which architectural registers have a write pending. Several issue-side
// grant checkers request a lock on a set of destination registers. One requester
// is granted per cycle, combinationally and round-robin. A port whose set overlaps
// a register that is already locked is skipped. Writeback ports release single
// registers by index.
//
// Ports
//   clk_i           clock; all state updates on the rising edge
//   arst_ni         asynchronous active-low reset
//   arb_req_i       [NP]      per-port lock request
//   arb_gnt_o       [NP]      per-port grant, at most one bit set
//   lock_req_i      [NP*NR]   per-port register set to lock (port p at [p*NR +: NR])
//   locks_o         [NR]      registered lock vector
//   unlock_valid_i  [NU]      per-port writeback-complete strobe
//   unlock_idx_i    [NU*IW]   per-port register index to unlock (port u at [u*IW +: IW])
//   flush_i         pipeline flush; suppresses grants, does not touch locks
//   busy_o          any lock held

package rv64g_pkg;
  localparam int unsigned NUM_REGS = 32;
endpackage

module reg_lock_arb #(
  parameter  int unsigned NP = 4,
  parameter  int unsigned NU = 2,
  localparam int unsigned NR = rv64g_pkg::NUM_REGS,
  localparam int unsigned IW = $clog2(NR)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic [NP-1:0]    arb_req_i,
  output logic [NP-1:0]    arb_gnt_o,
  input  logic [NP*NR-1:0] lock_req_i,
  output logic [NR-1:0]    locks_o,
  input  logic [NU-1:0]    unlock_valid_i,
  input  logic [NU*IW-1:0] unlock_idx_i,
  input  logic             flush_i,
  output logic             busy_o
);

  // A 1-bit pointer is kept even for NP == 1 so the vector never collapses to zero width.
  localparam int unsigned RrW  = (NP > 1) ? $clog2(NP) : 1;
  // The decode covers every encodable index. Indices >= NR land in the upper bits,
  // which are dropped, so out-of-range unlocks are ignored without a compare.
  localparam int unsigned DecW = 1 << IW;

  logic [NR-1:0]   locks_q, locks_d;
  logic [RrW-1:0]  rr_q, rr_d;

  logic [NP-1:0]   eligible;
  logic            gnt_valid;
  logic [RrW-1:0]  gnt_idx;
  logic [RrW-1:0]  cand;

  logic [DecW-1:0] unlock_dec;
  logic [NR-1:0]   unlock_mask;
  logic [NR-1:0]   set_mask;

  // A requester is eligible only if none of its registers are locked at the moment.
  always_comb begin
    eligible = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      eligible[p] = arb_req_i[p] & ~(|(lock_req_i[p*NR +: NR] & locks_q));
    end
  end

  // Round-robin search, starting at rr_q and wrapping at NP.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      cand = RrW'((32'(rr_q) + i) % NP);
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    // Reset gates the grant combinationally, so the grant is not only cleared on a clock edge.
    if (!arst_ni || flush_i) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    arb_gnt_o = '0;
    if (gnt_valid) begin
      arb_gnt_o = NP'(1) << gnt_idx;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_valid) begin
      rr_d = RrW'((32'(gnt_idx) + 1) % NP);
    end
  end

  // Duplicate indices simply set the same decode bit twice.
  always_comb begin
    unlock_dec = '0;
    for (int unsigned u = 0; u < NU; u++) begin
      if (unlock_valid_i[u]) begin
        unlock_dec[unlock_idx_i[u*IW +: IW]] = 1'b1;
      end
    end
    unlock_mask = unlock_dec[NR-1:0];
  end

  // x0 is hardwired zero and never needs a lock.
  always_comb begin
    set_mask = '0;
    if (gnt_valid) begin
      set_mask = lock_req_i[32'(gnt_idx)*NR +: NR];
    end
    set_mask[0] = 1'b0;
  end

  // The set is applied after the clear, so a new lock wins over a same-cycle unlock.
  // A flush only suppresses the grant; writebacks in flight still release their locks.
  always_comb begin
    locks_d = (locks_q & ~unlock_mask) | set_mask;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      locks_q <= '0;
      rr_q    <= '0;
    end else begin
      locks_q <= locks_d;
      rr_q    <= rr_d;
    end
  end

  assign locks_o = locks_q;
  assign busy_o  = |locks_q;

endmodule

// File: tb/tb_reg_lock_arb.sv
`timescale 1ns / 1ps

module tb_reg_lock_arb;

  localparam int NP = 4;
  localparam int NU = 2;
  localparam int NR = 32;
  localparam int IW = 5;

  logic              clk     = 1'b0;
  logic              arst_ni = 1'b0;
  logic [NP-1:0]     arb_req = '0;
  logic [NP-1:0]     gnt;
  logic [NP*NR-1:0]  lock_req = '0;
  logic [NR-1:0]     locks;
  logic [NU-1:0]     uv = '0;
  logic [NU*IW-1:0]  uidx = '0;
  logic              flush = 1'b0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_lock_arb #(
    .NP(NP),
    .NU(NU)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (arst_ni),
    .arb_req_i     (arb_req),
    .arb_gnt_o     (gnt),
    .lock_req_i    (lock_req),
    .locks_o       (locks),
    .unlock_valid_i(uv),
    .unlock_idx_i  (uidx),
    .flush_i       (flush),
    .busy_o        (busy)
  );

  // ---------------- behavioural model ----------------
  logic [NR-1:0] m_locks = '0;
  int            m_rr    = 0;

  // Which port should win right now, or -1 for none.
  function automatic int model_grant();
    if (!arst_ni || flush) return -1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_rr + i) % NP;
      if (arb_req[p] && ((lock_req[p*NR +: NR] & m_locks) == '0)) return p;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] model_gnt();
    int g;
    g = model_grant();
    if (g < 0) return '0;
    return NP'(1) << g;
  endfunction

  function automatic logic [NR-1:0] model_next_locks();
    logic [NR-1:0] nl;
    int g;
    nl = m_locks;
    for (int u = 0; u < NU; u++) begin
      if (uv[u] && (int'(uidx[u*IW +: IW]) < NR)) nl[uidx[u*IW +: IW]] = 1'b0;
    end
    g = model_grant();
    if (g >= 0) nl = nl | (lock_req[g*NR +: NR] & ~32'h1);
    return nl;
  endfunction

  function automatic int model_next_rr();
    int g;
    g = model_grant();
    return (g >= 0) ? (g + 1) % NP : m_rr;
  endfunction

  always @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      m_locks <= '0;
      m_rr    <= 0;
    end else begin
      m_locks <= model_next_locks();
      m_rr    <= model_next_rr();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mdl_gnt", 32'(gnt), 32'(model_gnt()));
    check("mdl_locks", locks, m_locks);
    check("mdl_busy", 32'(busy), 32'(m_locks != '0));
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic lr(input int p, input logic [31:0] v);
    lock_req[p*NR +: NR] = v;
  endtask

  task automatic unl(input logic [1:0] v, input int i0, input int i1);
    uv   = v;
    uidx = {IW'(i1), IW'(i0)};
  endtask

  initial begin
    // Reset held with live requests: grant must stay low.
    arb_req = 4'b1111;
    lr(0, 32'h2);
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_locks", locks, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    next();
    arst_ni  = 1'b1;
    arb_req  = '0;
    lock_req = '0;

    // Round-robin over ports 0 and 2 with disjoint sets.
    arb_req = 4'b0101;
    lr(0, 32'h2);
    lr(2, 32'h4);
    @(negedge clk);
    check("rr_a_gnt", 32'(gnt), 32'h1);
    next();
    lr(0, 32'h8);
    @(negedge clk);
    check("rr_b_gnt", 32'(gnt), 32'h4);
    check("rr_b_locks", locks, 32'h2);
    next();
    lr(2, 32'h10);
    @(negedge clk);
    check("rr_c_gnt", 32'(gnt), 32'h1);
    check("rr_c_locks", locks, 32'h6);
    next();

    // Release 1,2 and lock 5 through port 0.
    arb_req  = 4'b0001;
    lock_req = '0;
    lr(0, 32'h20);
    unl(2'b11, 1, 2);
    @(negedge clk);
    check("d_gnt", 32'(gnt), 32'h1);
    check("d_locks", locks, 32'he);
    next();

    // Port 1 wants locked reg 5 and is skipped; port 2 takes reg 7.
    arb_req  = 4'b0110;
    lock_req = '0;
    lr(1, 32'h20);
    lr(2, 32'h80);
    unl(2'b00, 0, 0);
    @(negedge clk);
    check("skip_gnt", 32'(gnt), 32'h4);
    check("skip_locks", locks, 32'h28);
    next();

    // Unlock and lock of reg 9 in the same cycle: the lock must stick.
    arb_req  = 4'b0001;
    lock_req = '0;
    lr(0, 32'h200);
    unl(2'b01, 9, 0);
    @(negedge clk);
    check("lw_gnt", 32'(gnt), 32'h1);
    check("lw_locks", locks, 32'ha8);
    next();
    arb_req = '0;
    unl(2'b11, 5, 7);
    @(negedge clk);
    check("lw_after", locks, 32'h2a8);
    next();

    // Lock reg 12 while releasing 9.
    arb_req  = 4'b0010;
    lock_req = '0;
    lr(1, 32'h1000);
    unl(2'b01, 9, 0);
    @(negedge clk);
    check("h_gnt", 32'(gnt), 32'h2);
    check("h_locks", locks, 32'h208);
    next();

    // Both unlock ports clear {3,12}.
    arb_req = '0;
    unl(2'b11, 3, 12);
    @(negedge clk);
    check("two_locks", locks, 32'h1008);
    check("two_busy", 32'(busy), 32'h1);
    next();

    // Lock {4,6}, then duplicate unlock of 6.
    arb_req  = 4'b0100;
    lock_req = '0;
    lr(2, 32'h50);
    unl(2'b00, 0, 0);
    @(negedge clk);
    check("two_clr", locks, 32'h0);
    check("two_idle", 32'(busy), 32'h0);
    check("j_gnt", 32'(gnt), 32'h4);
    next();
    arb_req = '0;
    unl(2'b11, 6, 6);
    @(negedge clk);
    check("dup_pre", locks, 32'h50);
    next();

    // Flush: no grant, pointer held, unlock of reg 4 still lands.
    flush   = 1'b1;
    arb_req = 4'b1111;
    lr(0, 32'h0010_0000);
    lr(1, 32'h0020_0000);
    lr(2, 32'h0040_0000);
    lr(3, 32'h0080_0000);
    unl(2'b01, 4, 0);
    @(negedge clk);
    check("fl_gnt", 32'(gnt), 32'h0);
    check("fl_locks", locks, 32'h10);
    next();
    flush = 1'b0;
    unl(2'b00, 0, 0);
    @(negedge clk);
    check("fl_unlock", locks, 32'h0);
    check("fl_rr_held", 32'(gnt), 32'h8);
    next();

    // Build locks = 0xF0.
    arb_req  = 4'b0001;
    lock_req = '0;
    lr(0, 32'hf0);
    unl(2'b01, 23, 0);
    @(negedge clk);
    check("n_gnt", 32'(gnt), 32'h1);
    check("n_locks", locks, 32'h0080_0000);
    next();
    arb_req = '0;
    unl(2'b00, 0, 0);
    @(negedge clk);
    check("f0_locks", locks, 32'hf0);

    // Reset pulse between edges; the first grant afterwards searches from port 0.
    #1;
    arb_req  = 4'b1001;
    lock_req = '0;
    lr(0, 32'h3);
    lr(3, 32'h100);
    arst_ni = 1'b0;
    #1;
    check("pulse_locks", locks, 32'h0);
    check("pulse_busy", 32'(busy), 32'h0);
    check("pulse_gnt", 32'(gnt), 32'h0);
    arst_ni = 1'b1;
    #1;
    check("post_gnt", 32'(gnt), 32'h1);
    next();
    arb_req = '0;
    @(negedge clk);
    check("x0_locks", locks, 32'h2);
    next();
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
